// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone classic initiator bridge.
// Holds the FSM state encoding, bus widths and the default timeout read data.
package wb_master_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-cycle watchdog for the initiator bridge; built only when WB_TIMEOUT_EN
// is defined. expired is asserted on the BUS cycle whose closing edge reaches TIMEOUT_CYCLES.
`ifdef WB_TIMEOUT_EN
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // enable already excludes ack, so an ack on the final cycle always wins
  assign expired = enable && (cnt == CNT_LAST);

endmodule
`endif

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: one outstanding single-beat command, registered bus outputs.
// Optional ack watchdog enabled by defining WB_TIMEOUT_EN.
module wb_master_bridge
  import wb_master_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = 255,
  parameter logic [DAT_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [SEL_W-1:0] cmd_sel_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [DAT_W-1:0] wbm_dat_i,
  output logic             busy_o
);

  state_e state;
  logic   accept;
  logic   expired;

  assign accept = (state == IDLE) && cmd_ready_o && cmd_valid_i;

`ifdef WB_TIMEOUT_EN
  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (accept),
    .enable ((state == BUS) && !wbm_ack_i),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            wbm_we_o    <= cmd_we_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= BUS;
          end
        end
        BUS: begin
          if (wbm_ack_i || expired) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            if (wbm_ack_i) begin
              rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
              rsp_err_o <= 1'b0;
            end else begin
              rsp_dat_o <= ERR_DATA;
              rsp_err_o <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          // ready returns with IDLE, so a waiting command is taken one edge later
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge; timeout scenarios are included when WB_TIMEOUT_EN is defined.
module tb_wb_master_bridge;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] sdat;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // {cyc, stb, we, cmd_ready, busy, rsp_valid, rsp_err}
  logic [6:0] ctl;
  assign ctl = {cyc, stb, we, cmd_ready, busy, rsp_valid, rsp_err};

  localparam logic [6:0] C_RST   = 7'b0000000;
  localparam logic [6:0] C_IDLE  = 7'b0001000;
  localparam logic [6:0] C_BUS_R = 7'b1100100;
  localparam logic [6:0] C_BUS_W = 7'b1110100;
  localparam logic [6:0] C_RESP  = 7'b0000110;
  localparam logic [6:0] C_RESPE = 7'b0000111;

  wb_master_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_sel_i  (cmd_sel),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (wdat),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (sdat),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_adr   = a;
    cmd_dat   = d;
    cmd_sel   = s;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; ack = 1'b0; sdat = '0;
    tick; tick;
    vectors++;
    if (ctl !== C_RST) begin
      miscompares++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST);
    end
    vectors++;
    if ({adr, wdat, sel, rsp_dat} !== 100'd0) begin
      miscompares++; $display("FAIL reset_data: adr %h dat %h sel %h rsp %h want all 0", adr, wdat, sel, rsp_dat);
    end
    rst = 1'b0;
    tick;
    vectors++;
    if (ctl !== C_IDLE) begin
      miscompares++; $display("FAIL reset_idle: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_write_zero_wait;
    issue(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
    tick;
    cmd_valid = 1'b0;
    vectors++;
    if ({ctl, adr, wdat, sel} !== {C_BUS_W, 32'h3000_0004, 32'h1234_5678, 4'hF}) begin
      miscompares++; $display("FAIL wr_bus: ctl %b adr %h dat %h sel %h", ctl, adr, wdat, sel);
    end
    ack = 1'b1;
    tick;
    ack = 1'b0;
    vectors++;
    if ({ctl, rsp_dat, wdat, sel} !== {C_RESP, 32'h0, 32'h1234_5678, 4'hF}) begin
      miscompares++; $display("FAIL wr_resp: ctl %b rsp %h dat %h sel %h want %b 0 12345678 f", ctl, rsp_dat, wdat, sel, C_RESP);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++;
    if (ctl !== C_IDLE) begin
      miscompares++; $display("FAIL wr_idle: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_read_wait_states;
    issue(1'b0, 32'h3800_0010, 32'h0, 4'h6);
    tick;
    cmd_valid = 1'b0; cmd_adr = 32'hFFFF_FFFF; cmd_sel = 4'h0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({ctl, adr, sel} !== {C_BUS_R, 32'h3800_0010, 4'h6}) begin
        miscompares++; $display("FAIL rd_bus_%0d: ctl %b adr %h sel %h", i, ctl, adr, sel);
      end
      if (i == 3) begin
        ack = 1'b1; sdat = 32'hA5A5_0001;
      end
      tick;
    end
    ack = 1'b0; sdat = '0;
    vectors++;
    if ({ctl, rsp_dat} !== {C_RESP, 32'hA5A5_0001}) begin
      miscompares++; $display("FAIL rd_resp: ctl %b rsp %h want %b a5a50001", ctl, rsp_dat, C_RESP);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++;
    if (ctl !== C_IDLE) begin
      miscompares++; $display("FAIL rd_idle: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_backpressure;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    tick;
    issue(1'b1, 32'h3000_0010, 32'h1111_2222, 4'h3);
    ack = 1'b1; sdat = 32'h0BAD_F00D;
    tick;
    ack = 1'b0; sdat = '0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({ctl, rsp_dat} !== {C_RESP, 32'h0BAD_F00D}) begin
        miscompares++; $display("FAIL bp_hold_%0d: ctl %b rsp %h want %b 0badf00d", i, ctl, rsp_dat, C_RESP);
      end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    vectors++;
    if (ctl !== C_IDLE) begin
      miscompares++; $display("FAIL bp_release: got %b want %b", ctl, C_IDLE);
    end
    tick;
    cmd_valid = 1'b0;
    vectors++;
    if ({ctl, adr, wdat, sel} !== {C_BUS_W, 32'h3000_0010, 32'h1111_2222, 4'h3}) begin
      miscompares++; $display("FAIL bp_next_cmd: ctl %b adr %h dat %h sel %h", ctl, adr, wdat, sel);
    end
    ack = 1'b1;
    tick;
    ack = 1'b0;
    tick;
    rsp_ready = 1'b0;
    vectors++;
    if (ctl !== C_IDLE) begin
      miscompares++; $display("FAIL bp_done: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp;
    issue(1'b0, 32'h3800_0000, 32'h0, 4'hF);
    ack = 1'b1; sdat = 32'h0000_0042; rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick;
      exp = (i % 3 == 0) ? C_BUS_R : (i % 3 == 1) ? C_RESP : C_IDLE;
      vectors++;
      if (ctl !== exp) begin
        miscompares++; $display("FAIL b2b_%0d: got %b want %b", i, ctl, exp);
      end
    end
    cmd_valid = 1'b0; ack = 1'b0; sdat = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_spurious_ack;
    ack = 1'b1; sdat = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (ctl !== C_IDLE) begin
        miscompares++; $display("FAIL spurious_%0d: got %b want %b", i, ctl, C_IDLE);
      end
    end
    ack = 1'b0; sdat = '0;
  endtask

  task automatic test_reset_mid_bus;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    tick;
    cmd_valid = 1'b0;
    tick;
    vectors++;
    if (ctl !== C_BUS_R) begin
      miscompares++; $display("FAIL rstmid_bus: got %b want %b", ctl, C_BUS_R);
    end
    rst = 1'b1;
    tick;
    vectors++;
    if (ctl !== C_RST) begin
      miscompares++; $display("FAIL rstmid_drop: got %b want %b", ctl, C_RST);
    end
    rst = 1'b0; ack = 1'b1; sdat = 32'h7777_7777;
    tick;
    ack = 1'b0; sdat = '0;
    vectors++;
    if (ctl !== C_IDLE) begin
      miscompares++; $display("FAIL rstmid_idle: got %b want %b", ctl, C_IDLE);
    end
    tick;
    vectors++;
    if (ctl !== C_IDLE) begin
      miscompares++; $display("FAIL rstmid_norsp: got %b want %b", ctl, C_IDLE);
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout;
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ctl !== C_BUS_R) begin
        miscompares++; $display("FAIL to_wait_%0d: got %b want %b", i, ctl, C_BUS_R);
      end
      tick;
    end
    vectors++;
    if ({ctl, rsp_dat} !== {C_RESPE, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL to_expire: ctl %b rsp %h want %b deadbeef", ctl, rsp_dat, C_RESPE);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout_tie;
    issue(1'b0, 32'h3800_0040, 32'h0, 4'hF);
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        ack = 1'b1; sdat = 32'h600D_CAFE;
      end
      tick;
    end
    ack = 1'b0; sdat = '0;
    vectors++;
    if ({ctl, rsp_dat} !== {C_RESP, 32'h600D_CAFE}) begin
      miscompares++; $display("FAIL to_tie: ctl %b rsp %h want %b 600dcafe", ctl, rsp_dat, C_RESP);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_write_zero_wait;
    test_read_wait_states;
    test_backpressure;
    test_back_to_back;
    test_spurious_ack;
    test_reset_mid_bus;
`ifdef WB_TIMEOUT_EN
    test_timeout;
    test_timeout_tie;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
